// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// grant identifiers and the bit positions used in one-hot grant vectors.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } gnt_t;

    localparam int IDX_IF = 0;
    localparam int IDX_LS = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. Purely combinational, one-hot grant out.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       req_if,
    input  logic       req_ls,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req_if && req_ls) begin
            if (last_gnt == GNT_IF) begin
                gnt[IDX_LS] = 1'b1;
            end else begin
                gnt[IDX_IF] = 1'b1;
            end
        end else begin
            gnt[IDX_IF] = req_if;
            gnt[IDX_LS] = req_ls;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with a
// single transaction in flight at a time and round-robin tie breaking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic                    ls_we,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_wmask,
    output logic                    ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ls_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_WIDTH / 8;

    state_t              state_reg, state_next;
    gnt_t                last_gnt_reg, last_gnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                we_reg, we_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [MASK_W-1:0]   wmask_reg, wmask_next;
    logic [1:0]          arb_gnt;
    logic                pick_ls;

    rr_arb2 u_rr_arb2 (
        .req_if   (if_req_valid),
        .req_ls   (ls_req_valid),
        .last_gnt (last_gnt_reg),
        .gnt      (arb_gnt)
    );

    assign pick_ls = arb_gnt[IDX_LS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            last_gnt_reg <= GNT_IF;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            wmask_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
            addr_reg     <= addr_next;
            we_reg       <= we_next;
            wdata_reg    <= wdata_next;
            wmask_reg    <= wmask_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        addr_next     = addr_reg;
        we_next       = we_reg;
        wdata_next    = wdata_reg;
        wmask_next    = wmask_reg;

        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_rsp_valid  = 1'b0;
        if_rdata      = '0;
        ls_rsp_valid  = 1'b0;
        ls_rdata      = '0;
        mem_req_valid = 1'b0;
        // Payload registers feed the memory port directly so it cannot move
        // while a request is stalled on mem_req_ready.
        mem_addr      = addr_reg;
        mem_we        = we_reg;
        mem_wdata     = wdata_reg;
        mem_wmask     = wmask_reg;

        unique case (state_reg)
            IDLE: begin
                // Readies are gated by reset because the reset itself is
                // asynchronous and the state register is already IDLE.
                if (rst && (arb_gnt != 2'b00)) begin
                    if_req_ready  = arb_gnt[IDX_IF];
                    ls_req_ready  = arb_gnt[IDX_LS];
                    last_gnt_next = pick_ls ? GNT_LS : GNT_IF;
                    addr_next     = pick_ls ? ls_addr : if_addr;
                    we_next       = pick_ls & ls_we;
                    wdata_next    = pick_ls ? ls_wdata : '0;
                    wmask_next    = pick_ls ? ls_wmask : '0;
                    state_next    = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    if (last_gnt_reg == GNT_LS) begin
                        ls_rsp_valid = 1'b1;
                        ls_rdata     = mem_rdata;
                    end else begin
                        if_rsp_valid = 1'b1;
                        if_rdata     = mem_rdata;
                    end
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the shared memory port.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rdata;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic [31:0] ls_addr = '0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_wmask = '0;
    logic        ls_rsp_valid;
    logic [31:0] ls_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: one outstanding transaction, owner 0=IF 1=LS, last winner.
    bit        m_busy = 0, m_issued = 0, m_owner = 0, m_last = 0;
    bit        m_we = 0;
    bit [31:0] m_addr = 0, m_wdata = 0;
    bit [3:0]  m_wmask = 0;

    int        n_if_rsp = 0, n_ls_rsp = 0, n_mreq = 0;
    bit [31:0] last_if_rdata = 0, last_ls_rdata = 0;
    bit        if_acc = 0, ls_acc = 0;
    bit        gnt_q[$];
    bit        mem_pend = 0;
    int        mem_cnt = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        bit e_if_rdy, e_ls_rdy, e_mreq, fire;
        #1;
        e_if_rdy = rst && !m_busy && if_req_valid && (!ls_req_valid || m_last);
        e_ls_rdy = rst && !m_busy && ls_req_valid && (!if_req_valid || !m_last);
        e_mreq   = rst && m_busy && !m_issued;
        fire     = rst && m_busy && m_issued && mem_rsp_valid;

        chk("if_req_ready", 64'(if_req_ready), 64'(e_if_rdy));
        chk("ls_req_ready", 64'(ls_req_ready), 64'(e_ls_rdy));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(e_mreq));
        chk("if_rsp_valid", 64'(if_rsp_valid), 64'(fire && !m_owner));
        chk("ls_rsp_valid", 64'(ls_rsp_valid), 64'(fire && m_owner));
        chk("if_rdata", 64'(if_rdata), 64'((fire && !m_owner) ? mem_rdata : 32'h0));
        chk("ls_rdata", 64'(ls_rdata), 64'((fire && m_owner) ? mem_rdata : 32'h0));
        if (e_mreq) begin
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_we", 64'(mem_we), 64'(m_we));
            chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
            if (m_owner) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        if (!rst) begin
            chk("rst_mem_addr", 64'(mem_addr), 64'h0);
            chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
            chk("rst_mem_we_wmask", 64'({mem_we, mem_wmask}), 64'h0);
        end

        if (if_rsp_valid) begin n_if_rsp++; last_if_rdata = if_rdata; end
        if (ls_rsp_valid) begin n_ls_rsp++; last_ls_rdata = ls_rdata; end
        if (mem_req_valid) n_mreq++;
        if_acc = if_req_valid && if_req_ready;
        ls_acc = ls_req_valid && ls_req_ready;
        if (if_acc) gnt_q.push_back(1'b0);
        if (ls_acc) gnt_q.push_back(1'b1);
        if (mem_req_valid && mem_req_ready) begin
            mem_pend = 1;
            mem_cnt  = $urandom_range(0, 3);
        end

        if (!rst) begin
            m_busy = 0; m_issued = 0; m_last = 0; mem_pend = 0;
        end else if (fire) begin
            m_busy = 0;
        end else if (e_mreq) begin
            if (mem_req_ready) m_issued = 1;
        end else if (e_if_rdy || e_ls_rdy) begin
            m_busy   = 1;
            m_issued = 0;
            m_owner  = e_ls_rdy;
            m_last   = e_ls_rdy;
            m_addr   = e_ls_rdy ? ls_addr : if_addr;
            m_we     = e_ls_rdy && ls_we;
            m_wdata  = ls_wdata;
            m_wmask  = e_ls_rdy ? ls_wmask : 4'h0;
        end
        @(negedge clk);
    endtask

    task automatic drive_mem(bit stray_en);
        mem_rdata = $urandom;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_pend = 0;
            end else begin
                mem_rsp_valid = 1'b0;
                mem_cnt--;
            end
        end else begin
            mem_rsp_valid = stray_en && ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic rand_drive();
        if (!if_req_valid || if_acc) begin
            if_req_valid = $urandom_range(0, 1) == 1;
            if_addr      = $urandom;
        end
        if (!ls_req_valid || ls_acc) begin
            ls_req_valid = $urandom_range(0, 1) == 1;
            ls_addr      = $urandom;
            ls_we        = $urandom_range(0, 1) == 1;
            ls_wdata     = $urandom;
            ls_wmask     = 4'($urandom);
        end
        mem_req_ready = $urandom_range(0, 3) != 0;
        drive_mem(1'b1);
    endtask

    task automatic idle_drain(int n);
        if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 1;
        for (int i = 0; i < n; i++) begin
            drive_mem(1'b0);
            step();
        end
        mem_rsp_valid = 0;
    endtask

    initial begin
        @(negedge clk);
        // Reset held, with requests pending: nothing may be granted.
        if_req_valid = 1; ls_req_valid = 1;
        step();
        step();
        if_req_valid = 0; ls_req_valid = 0;
        rst = 1;
        step();

        // Round-robin from reset: LS first, then alternate.
        gnt_q.delete();
        mem_pend = 0;
        if_req_valid = 1; if_addr = 32'h1000;
        ls_req_valid = 1; ls_addr = 32'h2000; ls_we = 0;
        mem_req_ready = 1;
        for (int i = 0; i < 30; i++) begin
            if (if_acc) if_addr = if_addr + 4;
            if (ls_acc) ls_addr = ls_addr + 4;
            drive_mem(1'b0);
            step();
        end
        chk("rr_count_ge4", 64'(gnt_q.size() >= 4), 64'h1);
        for (int i = 0; i < 4 && i < gnt_q.size(); i++)
            chk($sformatf("rr_order%0d", i), 64'(gnt_q[i]), 64'((i % 2) == 0));
        $display("rr: %0d grants observed", gnt_q.size());
        idle_drain(8);

        // Single fetch, memory answers two cycles after accepting.
        n_if_rsp = 0; n_ls_rsp = 0;
        if_req_valid = 1; if_addr = 32'h8000_0000; mem_req_ready = 1;
        step();
        if_req_valid = 0;
        step();
        step();
        mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
        step();
        mem_rsp_valid = 0;
        step();
        chk("fetch_if_rsp_cnt", 64'(n_if_rsp), 64'd1);
        chk("fetch_ls_rsp_cnt", 64'(n_ls_rsp), 64'd0);
        chk("fetch_rdata", 64'(last_if_rdata), 64'h413);
        $display("fetch: if_rsp=%0d ls_rsp=%0d rdata=%08h", n_if_rsp, n_ls_rsp, last_if_rdata);

        // Store stalled by mem_req_ready for three cycles.
        n_if_rsp = 0; n_ls_rsp = 0; n_mreq = 0;
        ls_req_valid = 1; ls_addr = 32'h8000_1000; ls_we = 1;
        ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'hF; mem_req_ready = 0;
        step();
        ls_req_valid = 0; ls_wdata = 0; ls_addr = 0; ls_wmask = 0; ls_we = 0;
        for (int i = 0; i < 3; i++) step();
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        step();
        mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
        step();
        mem_rsp_valid = 0;
        step();
        chk("store_mreq_cycles", 64'(n_mreq), 64'd4);
        chk("store_ls_rsp_cnt", 64'(n_ls_rsp), 64'd1);
        chk("store_if_rsp_cnt", 64'(n_if_rsp), 64'd0);
        $display("store: mreq_cycles=%0d ls_rsp=%0d", n_mreq, n_ls_rsp);

        // Stray response while idle, then a normal grant.
        n_if_rsp = 0; n_ls_rsp = 0;
        mem_rsp_valid = 1;
        step();
        step();
        mem_rsp_valid = 0;
        if_req_valid = 1; if_addr = 32'h40;
        step();
        chk("stray_rsp_cnt", 64'(n_if_rsp + n_ls_rsp), 64'd0);
        chk("stray_then_grant", 64'(if_acc), 64'h1);
        $display("stray: rsp=%0d grant_after=%0d", n_if_rsp + n_ls_rsp, if_acc);
        idle_drain(8);

        // Reset in WAIT abandons the transaction.
        n_if_rsp = 0; n_ls_rsp = 0;
        if_req_valid = 1; if_addr = 32'h100; mem_req_ready = 1;
        step();
        if_req_valid = 0;
        step();
        mem_req_ready = 0;
        step();
        rst = 0; if_req_valid = 1;
        step();
        rst = 1; if_req_valid = 0; mem_rsp_valid = 1; mem_rdata = 32'hAAAA_5555;
        step();
        mem_rsp_valid = 0; if_req_valid = 1; if_addr = 32'h200;
        step();
        chk("rst_wait_rsp_cnt", 64'(n_if_rsp + n_ls_rsp), 64'd0);
        chk("rst_wait_regrant", 64'(if_acc), 64'h1);
        $display("reset-in-wait: rsp=%0d regrant=%0d", n_if_rsp + n_ls_rsp, if_acc);
        idle_drain(8);

        // Randomized traffic.
        n_if_rsp = 0; n_ls_rsp = 0; gnt_q.delete();
        mem_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            step();
        end
        idle_drain(10);
        chk("random_made_progress", 64'(n_if_rsp > 10 && n_ls_rsp > 10), 64'h1);
        $display("random: grants=%0d if_rsp=%0d ls_rsp=%0d", gnt_q.size(), n_if_rsp, n_ls_rsp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
